// File: rtl/count_ext_monitor_if.sv
// Purpose: bundles the counter sample, clear and snapshot handshake signals of count_ext_monitor.
// Latency: none, this is wiring only.
// Backpressure: snap_ready from the consumer side holds snap_valid/snap_data until accepted.
// Ports: count/clear/snap_req/snap_ready flow into the monitor; ext_count, wrap, step_err,
//        snap_valid, snap_data and snap_ovr flow out of it.
interface count_ext_monitor_if #(
  parameter int UPPER_W = 4
);
  logic [3:0]         count;
  logic               clear;
  logic               snap_req;
  logic               snap_ready;
  logic [UPPER_W+3:0] ext_count;
  logic               wrap;
  logic               step_err;
  logic               snap_valid;
  logic [UPPER_W+3:0] snap_data;
  logic               snap_ovr;

  // Driver side: the counter source and the snapshot consumer.
  modport master (
    output count, clear, snap_req, snap_ready,
    input  ext_count, wrap, step_err, snap_valid, snap_data, snap_ovr
  );

  // Monitor side.
  modport slave (
    input  count, clear, snap_req, snap_ready,
    output ext_count, wrap, step_err, snap_valid, snap_data, snap_ovr
  );
endinterface

// File: rtl/count_ext_monitor.sv
// Purpose: extends a sampled 4-bit counter to UPPER_W+4 bits, flags wraps and illegal steps,
//          and holds a one-entry snapshot of the extended count.
// Latency: count -> ext_count/wrap/step_err 1 cycle; snap_req -> snap_valid 1 cycle.
// Backpressure: snapshot slot held until snap_ready; a request against a full, non-accepting
//               slot is dropped and recorded in the sticky snap_ovr flag.
// Ports: i_clk (rising edge), i_rst (async, active high), io_mon (count_ext_monitor_if.slave).
// Build option: define COUNT_EXT_STEP_CHECK_EN to implement illegal-step detection; otherwise
//               step_err is tied low.
module count_ext_monitor #(
  parameter int UPPER_W = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  count_ext_monitor_if.slave    io_mon
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } snap_state_e;

  logic [3:0]         r_prev;
  logic               r_primed;
  logic [UPPER_W-1:0] r_upper;
  logic               r_wrap;
  logic               r_snap_ovr;
  logic [UPPER_W+3:0] r_snap_data;
  snap_state_e        r_snap_state;

  snap_state_e        w_snap_state_nxt;
  logic               w_snap_load;
  logic               w_ovr_set;
  logic               w_wrap_det;
  logic [UPPER_W+3:0] w_ext_count;

  assign w_ext_count = {r_upper, r_prev};

  // Only a 15 -> 0 step counts as a wrap; without priming, a stale r_prev
  // (from before reset/clear) must not be compared against the new sample.
  assign w_wrap_det = r_primed && (r_prev == 4'hF) && (io_mon.count == 4'h0);

  // Extension, priming and sticky overflow. Clear wins over detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev     <= '0;
      r_primed   <= 1'b0;
      r_upper    <= '0;
      r_wrap     <= 1'b0;
      r_snap_ovr <= 1'b0;
    end else begin
      r_prev <= io_mon.count;
      if (io_mon.clear) begin
        r_primed   <= 1'b0;
        r_upper    <= '0;
        r_wrap     <= 1'b0;
        r_snap_ovr <= 1'b0;
      end else begin
        r_primed <= 1'b1;
        r_wrap   <= w_wrap_det;
        if (w_wrap_det) begin
          r_upper <= r_upper + UPPER_W'(1);
        end
        if (w_ovr_set) begin
          r_snap_ovr <= 1'b1;
        end
      end
    end
  end

`ifdef COUNT_EXT_STEP_CHECK_EN
  logic       r_step_err;
  logic       w_step_bad;
  logic [3:0] w_prev_inc;

  // Hold or +1 mod 16 are the only legal moves; 15 -> 0 falls out of the mod-16 increment.
  assign w_prev_inc = r_prev + 4'd1;
  assign w_step_bad = r_primed && (io_mon.count != r_prev) && (io_mon.count != w_prev_inc);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_step_err <= 1'b0;
    end else if (io_mon.clear) begin
      r_step_err <= 1'b0;
    end else if (w_step_bad) begin
      r_step_err <= 1'b1;
    end
  end

  assign io_mon.step_err = r_step_err;
`else
  assign io_mon.step_err = 1'b0;
`endif

  // Snapshot slot: state register and captured data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_snap_state <= S_EMPTY;
      r_snap_data  <= '0;
    end else begin
      r_snap_state <= w_snap_state_nxt;
      if (w_snap_load) begin
        r_snap_data <= w_ext_count;
      end
    end
  end

  // Snapshot next-state. A request while full is only honoured if the
  // current entry is being accepted on the same edge.
  always_comb begin
    w_snap_state_nxt = r_snap_state;
    w_snap_load      = 1'b0;
    w_ovr_set        = 1'b0;
    case (r_snap_state)
      S_EMPTY: begin
        if (io_mon.snap_req) begin
          w_snap_load      = 1'b1;
          w_snap_state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (io_mon.snap_req && io_mon.snap_ready) begin
          w_snap_load = 1'b1;
        end else if (io_mon.snap_ready) begin
          w_snap_state_nxt = S_EMPTY;
        end else if (io_mon.snap_req) begin
          w_ovr_set = 1'b1;
        end
      end
      default: begin
        w_snap_state_nxt = S_EMPTY;
      end
    endcase
  end

  assign io_mon.ext_count  = w_ext_count;
  assign io_mon.wrap       = r_wrap;
  assign io_mon.snap_valid = (r_snap_state == S_FULL);
  assign io_mon.snap_data  = r_snap_data;
  assign io_mon.snap_ovr   = r_snap_ovr;

endmodule

// File: doc/count_ext_monitor.md
# count_ext_monitor

Downstream consumer of the 4-bit free-running counter. Samples the counter's `count[3:0]` each clock, detects 15→0 wrap-around, and extends the count to 8 bits with an internal upper nibble. Flags illegal steps and offers a one-entry valid/ready snapshot port, so control logic can read a coherent 8-bit value without racing the counter.

## Interface
- `UPPER_W`, default 4: width of the internal wrap counter; `ext_count` width = `UPPER_W+4`.
- `clk` input 1: sole clock, rising edge; same clock as the upstream counter.
- `rst` input 1: asynchronous, active-high reset.
- `count` input 4: upstream counter value.
- `clear` input 1: synchronous clear of the extension and sticky flags.
- `snap_req` input 1: one-cycle request to capture `ext_count`.
- `snap_ready` input 1: consumer accepts `snap_data`.
- `ext_count` output UPPER_W+4: `{upper, prev}`, registered.
- `wrap` output 1: one-cycle pulse per detected 15→0 wrap.
- `step_err` output 1: sticky illegal-step flag.
- `snap_valid` output 1: `snap_data` holds an unaccepted snapshot.
- `snap_data` output UPPER_W+4: captured `ext_count`.
- `snap_ovr` output 1: sticky; a request arrived while the slot was full.

## Operation
- `prev` register samples `count` every cycle. `primed` flag is set on the first sample after reset or clear. Comparisons happen only when `primed`=1.
- Legal step: `count`==`prev` (hold) or `count`==`prev`+1 mod 16.
- Wrap: `primed` & `prev`==4'hF & `count`==4'h0 → next cycle `wrap`=1 and `upper` increments mod 2^UPPER_W. `upper` all-ones wraps silently to 0.
- Illegal step: any other (`prev`,`count`) pair while primed → `step_err` set, held until `clear`/`rst`. `upper` does not change on an illegal step.
- Snapshot FSM, two states:
  - EMPTY: `snap_req` → load `snap_data`←`ext_count` as presented that cycle, go to FULL.
  - FULL: `snap_ready` & !`snap_req` → go to EMPTY. `snap_ready` & `snap_req` → reload and stay FULL. !`snap_ready` & `snap_req` → request dropped, `snap_data` unchanged, `snap_ovr` set.
- `clear`: `upper`←0, `primed`←0, `step_err`←0, `snap_ovr`←0, `wrap`←0. `clear` has priority over wrap and error detection in the same cycle. It does not affect the snapshot FSM or `snap_data`.
- `rst`: every register goes to 0 immediately. Outputs: `ext_count`=0, `wrap`=0, `step_err`=0, `snap_valid`=0, `snap_data`=0, `snap_ovr`=0, `primed`=0.

## Timing
- `count` to `ext_count` low nibble: 1 cycle.
- Wrap edge (`count` shows 0 after 15) to `wrap` pulse and `upper` increment: 1 cycle, coincident with `ext_count` low nibble showing 0.
- `snap_req` to `snap_valid`: 1 cycle. Handshake completes on the rising edge with `snap_valid`&`snap_ready`.
- `snap_data` is stable while `snap_valid`=1 and not accepted.
- First cycle after `rst` deassertion or `clear`: sample only. No wrap or error is possible.
- `rst` asserted mid-snapshot discards the snapshot. No partial handshake survives.

## Configuration
- `COUNT_EXT_STEP_CHECK_EN` defined: illegal-step detection and `step_err` are implemented as above.
- Not defined: comparator logic is omitted and `step_err` is tied to 0. Wrap detection still requires `count`==0 after `prev`==15. Any other jump only updates `prev`.

## Test plan
- Reset, then drive `count` 0,1,…,15,0,1 on consecutive cycles → a single `wrap` pulse the cycle `ext_count` goes 8'h0F→8'h10; `step_err`=0.
- Run 16 full wraps with `UPPER_W`=4 → `ext_count` returns to 8'h00 after 8'hFF; 16 `wrap` pulses.
- `count` jumps 3→7 with the macro defined → `step_err`=1 next cycle and stays set through further legal counting; `clear` → 0. Without the macro → `step_err` stays 0.
- `snap_req` at `ext_count`=8'h25 with `snap_ready`=0 for 5 cycles → `snap_valid`=1 and `snap_data`=8'h25 held. A second `snap_req` in that window → `snap_ovr`=1 and data unchanged.
- `snap_req` together with `snap_ready` while FULL → data reloads to the current `ext_count`; `snap_valid` stays 1.
- Assert `rst` mid-count with `upper`=3 and `snap_valid`=1 → all outputs 0 immediately. The first post-reset sample 4'h0 after a pre-reset `prev` of 15 must not produce `wrap`.
